// File: rtl/encout_pkg.sv
// Shared quadrature definitions: decoder states, phase-index mapping and
// edge-counter limits, common to the phase generator and the input decoder.
package encout_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } enc_state_t;

  localparam logic [15:0] EDG_MAX = 16'h7FFF;
  localparam logic [15:0] EDG_MIN = 16'h8000;

  // (A,B) level pair to phase index; must match the generator's poscnt[1:0]
  function automatic logic [1:0] phase_idx(input logic a, input logic b);
    logic [1:0] idx;
    case ({a, b})
      2'b10:   idx = 2'd0;
      2'b00:   idx = 2'd1;
      2'b01:   idx = 2'd2;
      default: idx = 2'd3;
    endcase
    return idx;
  endfunction

  function automatic logic [15:0] edg_step(input logic [15:0] cnt,
                                           input logic up,
                                           input logic dn);
    logic [15:0] res;
    res = cnt;
    if (up && (cnt != EDG_MAX)) res = cnt + 16'd1;
    else if (dn && (cnt != EDG_MIN)) res = cnt - 16'd1;
    return res;
  endfunction

endpackage

// File: rtl/encin_phase_dec_if.sv
// Register-block side of the encoder-input decoder: configuration in,
// position/edge/status out.
interface encin_phase_dec_if #(
  parameter int FILT_W = 4
);

  logic              i_ence;
  logic              i_pol;
  logic [15:0]       i_posmax;
  logic [15:0]       i_poscnt_int;
  logic              i_set_poscnt;
  logic [FILT_W-1:0] i_filt_len;
  logic              i_zclr_en;
  logic              i_err_clr;
  logic              i_elc_intr;

  logic [15:0]       o_poscnt;
  logic [15:0]       o_edgcnt;
  logic [15:0]       o_edgcap;
  logic              o_cap_vld;
  logic              o_dir;
  logic              o_zdet;
  logic              o_err;
  logic              o_err_sts;

  modport master (
    output i_ence, i_pol, i_posmax, i_poscnt_int, i_set_poscnt,
           i_filt_len, i_zclr_en, i_err_clr, i_elc_intr,
    input  o_poscnt, o_edgcnt, o_edgcap, o_cap_vld, o_dir,
           o_zdet, o_err, o_err_sts
  );

  modport slave (
    input  i_ence, i_pol, i_posmax, i_poscnt_int, i_set_poscnt,
           i_filt_len, i_zclr_en, i_err_clr, i_elc_intr,
    output o_poscnt, o_edgcnt, o_edgcap, o_cap_vld, o_dir,
           o_zdet, o_err, o_err_sts
  );

endinterface

// File: rtl/encin_pin_filt.sv
// One encoder pin: synchronizer chain followed by a stability filter that
// accepts a level once it has been steady for i_filt_len+1 cycles.
module encin_pin_filt #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_W      = 4
) (
  input  logic              i_pclk,
  input  logic              i_presetn,
  input  logic              i_pin,
  input  logic [FILT_W-1:0] i_filt_len,
  output logic              o_level
);

  localparam logic [FILT_W-1:0] CNT_SAT = '1;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_last;
  logic [FILT_W-1:0]      r_run;
  logic                   r_level;
  logic                   w_sync;
  logic [FILT_W-1:0]      w_run;

  assign w_sync = r_sync[SYNC_STAGES-1];

  // w_run = number of cycles, beyond the first, that w_sync has held its value
  always_comb begin
    w_run = '0;
    if (w_sync == r_last) begin
      w_run = (r_run == CNT_SAT) ? CNT_SAT : r_run + 1'b1;
    end
  end

  always_ff @(posedge i_pclk or negedge i_presetn) begin
    if (!i_presetn) begin
      r_sync  <= '0;
      r_last  <= 1'b0;
      r_run   <= '0;
      r_level <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_pin};
      r_last <= w_sync;
      r_run  <= w_run;
      if (w_run >= i_filt_len) begin
        r_level <= w_sync;
      end
    end
  end

  assign o_level = r_level;

endmodule

// File: rtl/encin_phase_dec.sv
// Quadrature encoder input decoder: filtered A/B/Z pins drive a wrapping
// position counter, a saturating signed edge counter and error/Z status.
module encin_phase_dec
  import encout_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_W      = 4
) (
  input  logic               i_pclk,
  input  logic               i_presetn,
  input  logic               i_pina,
  input  logic               i_pinb,
  input  logic               i_pinz,
  encin_phase_dec_if.slave   ctl
);

  logic        w_fa;
  logic        w_fb;
  logic        w_fz;
  logic [1:0]  w_idx;
  logic [1:0]  w_d;
  logic        w_up;
  logic        w_dn;
  logic        w_err;
  logic        w_ld_ref;
  logic        w_zclr;
  logic [15:0] w_pos_nxt;
  logic [15:0] w_edg_step;
  enc_state_t  w_state_nxt;

  enc_state_t  r_state;
  logic [1:0]  r_ref;
  logic [15:0] r_pos;
  logic [15:0] r_edg;
  logic [15:0] r_cap;
  logic        r_cap_vld;
  logic        r_dir;
  logic        r_zprev;
  logic        r_zdet;
  logic        r_err;
  logic        r_err_sts;

  encin_pin_filt #(.SYNC_STAGES(SYNC_STAGES), .FILT_W(FILT_W)) u_filt_a (
    .i_pclk     (i_pclk),
    .i_presetn  (i_presetn),
    .i_pin      (i_pina),
    .i_filt_len (ctl.i_filt_len),
    .o_level    (w_fa)
  );

  encin_pin_filt #(.SYNC_STAGES(SYNC_STAGES), .FILT_W(FILT_W)) u_filt_b (
    .i_pclk     (i_pclk),
    .i_presetn  (i_presetn),
    .i_pin      (i_pinb),
    .i_filt_len (ctl.i_filt_len),
    .o_level    (w_fb)
  );

  encin_pin_filt #(.SYNC_STAGES(SYNC_STAGES), .FILT_W(FILT_W)) u_filt_z (
    .i_pclk     (i_pclk),
    .i_presetn  (i_presetn),
    .i_pin      (i_pinz),
    .i_filt_len (ctl.i_filt_len),
    .o_level    (w_fz)
  );

  assign w_idx = phase_idx(w_fa, w_fb ^ ctl.i_pol);
  assign w_d   = w_idx - r_ref;

  // PRIME only re-references, so edges seen while disabled never count
  always_comb begin
    w_state_nxt = r_state;
    w_ld_ref    = 1'b0;
    w_up        = 1'b0;
    w_dn        = 1'b0;
    w_err       = 1'b0;
    case (r_state)
      IDLE: begin
        if (ctl.i_ence) w_state_nxt = PRIME;
      end
      PRIME: begin
        w_ld_ref    = 1'b1;
        w_state_nxt = RUN;
      end
      RUN: begin
        w_ld_ref = 1'b1;
        case (w_d)
          2'd1:    w_up  = 1'b1;
          2'd3:    w_dn  = 1'b1;
          2'd2:    w_err = 1'b1;
          default: ;
        endcase
        if (!ctl.i_ence) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_zclr = ctl.i_zclr_en & r_zdet & (r_state == RUN);

  always_comb begin
    w_pos_nxt = r_pos;
    if (ctl.i_set_poscnt) begin
      w_pos_nxt = ctl.i_poscnt_int;
    end else if (w_zclr) begin
      w_pos_nxt = '0;
    end else if (w_up) begin
      w_pos_nxt = (r_pos >= ctl.i_posmax) ? 16'd0 : r_pos + 16'd1;
    end else if (w_dn) begin
      w_pos_nxt = (r_pos == 16'd0) ? ctl.i_posmax : r_pos - 16'd1;
    end
  end

  assign w_edg_step = edg_step(r_edg, w_up, w_dn);

  always_ff @(posedge i_pclk or negedge i_presetn) begin
    if (!i_presetn) begin
      r_state <= IDLE;
      r_ref   <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      if (w_ld_ref) r_ref <= w_idx;
    end
  end

  // A capture takes the count including this cycle's step, then restarts
  always_ff @(posedge i_pclk or negedge i_presetn) begin
    if (!i_presetn) begin
      r_pos     <= '0;
      r_edg     <= '0;
      r_cap     <= '0;
      r_cap_vld <= 1'b0;
      r_dir     <= 1'b0;
      r_zprev   <= 1'b0;
      r_zdet    <= 1'b0;
      r_err     <= 1'b0;
      r_err_sts <= 1'b0;
    end else begin
      r_pos     <= w_pos_nxt;
      r_cap_vld <= ctl.i_elc_intr;
      if (ctl.i_elc_intr) begin
        r_cap <= w_edg_step;
        r_edg <= '0;
      end else begin
        r_edg <= w_edg_step;
      end
      if (w_up || w_dn) r_dir <= w_up;
      r_zprev <= w_fz;
      r_zdet  <= w_fz & ~r_zprev;
      r_err   <= w_err;
      if (w_err) begin
        r_err_sts <= 1'b1;
      end else if (ctl.i_err_clr) begin
        r_err_sts <= 1'b0;
      end
    end
  end

  assign ctl.o_poscnt  = r_pos;
  assign ctl.o_edgcnt  = r_edg;
  assign ctl.o_edgcap  = r_cap;
  assign ctl.o_cap_vld = r_cap_vld;
  assign ctl.o_dir     = r_dir;
  assign ctl.o_zdet    = r_zdet;
  assign ctl.o_err     = r_err;
  assign ctl.o_err_sts = r_err_sts;

endmodule
